// File: rtl/sdhci_cmd_tx.sv
// SD host CMD-line transmitter: serializes a 48-bit command frame
// (start, dir, index, arg, CRC7, end) one bit per SD-clock strobe.
// Ports: clk_i/rst_i (sync, active-high), sd_clk_en_i bit strobe,
//   cmd_valid_i/cmd_ready_o with cmd_index_i/cmd_arg_i, abort_i,
//   sd_cmd_o/sd_cmd_en_o pad drive, busy_o, done_o (end-bit pulse).
// Option: define SDHCI_CMD_TX_NCC_EN to hold off NccCycles strobes
//   after the end bit before accepting the next command.
module sdhci_cmd_tx #(
  parameter int unsigned NccCycles = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sd_clk_en_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  input  logic        abort_i,
  output logic        sd_cmd_o,
  output logic        sd_cmd_en_o,
  output logic        busy_o,
  output logic        done_o
);

`ifdef SDHCI_CMD_TX_NCC_EN
  localparam bit NccOn = 1'b1;
`else
  localparam bit NccOn = 1'b0;
`endif

  // Zero when the feature is off, so the NCC state is never entered.
  localparam int unsigned NccEff = NccOn ? NccCycles : 0;
  localparam logic [7:0] NccLast = 8'(NccEff - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    NCC
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [39:0] shreg;
  logic [6:0]  crc;
  logic [5:0]  cnt;
  logic [7:0]  ncc_cnt;
  logic        hs;

  function automatic logic [6:0] crc7_step(
    input logic [6:0] c,
    input logic       b
  );
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign hs = cmd_valid_i & cmd_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (hs) state_nxt = LOAD;
      end
      LOAD: begin
        if (abort_i) begin
          state_nxt = IDLE;
        end else if (sd_clk_en_i) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (abort_i) begin
          state_nxt = IDLE;
        end else if (sd_clk_en_i && cnt == 6'd0) begin
          state_nxt = (NccEff != 0) ? NCC : IDLE;
        end
      end
      NCC: begin
        if (abort_i) begin
          state_nxt = IDLE;
        end else if (sd_clk_en_i && ncc_cnt == NccLast) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is held low during the done cycle so a new command
  // can only start the clk after the end bit completes.
  always_comb begin
    cmd_ready_o = (state == IDLE) && !done_o;
    busy_o      = (state == SHIFT) || (state == NCC);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg       <= '0;
      crc         <= '0;
      cnt         <= '0;
      ncc_cnt     <= '0;
      sd_cmd_o    <= 1'b1;
      sd_cmd_en_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (state != IDLE && abort_i) begin
        sd_cmd_o    <= 1'b1;
        sd_cmd_en_o <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (hs) begin
              shreg <= {2'b01, cmd_index_i, cmd_arg_i};
              crc   <= '0;
              cnt   <= '0;
            end
          end
          LOAD: begin
            if (sd_clk_en_i) begin
              sd_cmd_o    <= shreg[39];
              sd_cmd_en_o <= 1'b1;
              crc         <= crc7_step(crc, shreg[39]);
              shreg       <= {shreg[38:0], 1'b0};
              cnt         <= 6'd47;
            end
          end
          SHIFT: begin
            if (sd_clk_en_i) begin
              if (cnt == 6'd0) begin
                sd_cmd_o    <= 1'b1;
                sd_cmd_en_o <= 1'b0;
                done_o      <= 1'b1;
                ncc_cnt     <= '0;
              end else begin
                cnt <= cnt - 6'd1;
                // cnt is the index of the bit on the line now;
                // the strobe moves to bit cnt-1.
                if (cnt > 6'd8) begin
                  sd_cmd_o <= shreg[39];
                  crc      <= crc7_step(crc, shreg[39]);
                  shreg    <= {shreg[38:0], 1'b0};
                end else if (cnt > 6'd1) begin
                  sd_cmd_o <= crc[6];
                  crc      <= {crc[5:0], 1'b0};
                end else begin
                  sd_cmd_o <= 1'b1;
                end
              end
            end
          end
          NCC: begin
            if (sd_clk_en_i) ncc_cnt <= ncc_cnt + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdhci_cmd_tx.sv
// Directed bench for sdhci_cmd_tx: frame contents, strobe timing,
// abort, reset and back-to-back request handling.
module tb_sdhci_cmd_tx;
  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic        valid;
  logic        ready;
  logic [5:0]  idx;
  logic [31:0] arg;
  logic        abort;
  logic        cmd;
  logic        en;
  logic        busy;
  logic        done;

  localparam logic [47:0] F0  = 48'h40_0000_0000_95;
  localparam logic [47:0] F8  = 48'h48_0000_01AA_87;
  localparam logic [47:0] F17 = 48'h51_0000_0000_55;

  int total  = 0;
  int passed = 0;

  sdhci_cmd_tx dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .sd_clk_en_i (stb),
    .cmd_valid_i (valid),
    .cmd_ready_o (ready),
    .cmd_index_i (idx),
    .cmd_arg_i   (arg),
    .abort_i     (abort),
    .sd_cmd_o    (cmd),
    .sd_cmd_en_o (en),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [47:0] obs,
                     input logic [47:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input logic s);
    stb = s;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [5:0] i, input logic [31:0] a);
    idx   = i;
    arg   = a;
    valid = 1'b1;
    tick(1'b0);
    valid = 1'b0;
  endtask

  task automatic run_frame(input int period, output logic [47:0] bits,
                           output int nbits, output int ndone,
                           output int lat, output int unstable);
    logic s;
    logic pc;
    logic pe;
    bits = '0;
    nbits = 0;
    ndone = 0;
    lat = 0;
    unstable = 0;
    for (int t = 1; t <= 400 && ndone == 0; t++) begin
      s  = ((t % period) == 0);
      pc = cmd;
      pe = en;
      tick(s);
      if (s && en) begin
        bits = {bits[46:0], cmd};
        nbits++;
      end
      if (!s && (cmd !== pc || en !== pe)) unstable++;
      if (done) begin
        ndone++;
        lat = t;
      end
    end
  endtask

  logic [47:0] bits;
  int nb, nd, lat, uns, w, cnt;

  initial begin
    rst = 1'b1; stb = 1'b0; valid = 1'b0; abort = 1'b0;
    idx = '0; arg = '0;
    tick(1'b0);
    tick(1'b1);
    chk("rst_ready", 48'(ready), 48'd1);
    chk("rst_cmd",   48'(cmd),   48'd1);
    chk("rst_en",    48'(en),    48'd0);
    chk("rst_busy",  48'(busy),  48'd0);
    chk("rst_done",  48'(done),  48'd0);
    rst = 1'b0;
    tick(1'b0);

    start(6'd0, 32'h0);
    chk("cmd0_ready_drop", 48'(ready), 48'd0);
    run_frame(1, bits, nb, nd, lat, uns);
    chk("cmd0_bits",  bits, F0);
    chk("cmd0_nbits", 48'(nb), 48'd48);
    chk("cmd0_done",  48'(nd), 48'd1);
    chk("cmd0_lat",   48'(lat), 48'd49);
    chk("cmd0_en_end", 48'(en), 48'd0);
    chk("cmd0_cmd_end", 48'(cmd), 48'd1);
    tick(1'b1);
    chk("cmd0_done_pulse", 48'(done), 48'd0);
    chk("cmd0_ready_back", 48'(ready), 48'd1);

    start(6'd8, 32'h1AA);
    run_frame(1, bits, nb, nd, lat, uns);
    chk("cmd8_bits",  bits, F8);
    chk("cmd8_nbits", 48'(nb), 48'd48);
    tick(1'b0);

    abort = 1'b1;
    start(6'd17, 32'h0);
    abort = 1'b0;
    chk("idle_abort_hs", 48'(ready), 48'd0);
    run_frame(1, bits, nb, nd, lat, uns);
    chk("cmd17_bits", bits, F17);
    chk("cmd17_done", 48'(nd), 48'd1);
    tick(1'b0);

    start(6'd0, 32'h0);
    run_frame(4, bits, nb, nd, lat, uns);
    chk("slow_bits",   bits, F0);
    chk("slow_stable", 48'(uns), 48'd0);
    chk("slow_lat", 48'(lat >= 188 && lat <= 196), 48'd1);
    tick(1'b0);

    start(6'd8, 32'h1AA);
    bits = '0;
    nb = 0;
    for (int t = 0; t < 40 && nb < 28; t++) begin
      tick(1'b1);
      if (en) begin
        bits = {bits[46:0], cmd};
        nb++;
      end
    end
    chk("abort_prefix", {20'd0, bits[27:0]}, F8 >> 20);
    chk("abort_busy", 48'(busy), 48'd1);
    abort = 1'b1;
    tick(1'b1);
    abort = 1'b0;
    chk("abort_en",    48'(en),    48'd0);
    chk("abort_cmd",   48'(cmd),   48'd1);
    chk("abort_done",  48'(done),  48'd0);
    chk("abort_ready", 48'(ready), 48'd1);
    cnt = 0;
    for (int t = 0; t < 60; t++) begin
      tick(1'b1);
      if (done || en) cnt++;
    end
    chk("abort_quiet", 48'(cnt), 48'd0);
    start(6'd0, 32'h0);
    run_frame(1, bits, nb, nd, lat, uns);
    chk("post_abort_bits", bits, F0);
    tick(1'b0);

    start(6'd17, 32'h0);
    for (int t = 0; t < 10; t++) tick(1'b1);
    chk("mid_busy", 48'(busy), 48'd1);
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0;
    chk("mrst_ready", 48'(ready), 48'd1);
    chk("mrst_en",    48'(en),    48'd0);
    chk("mrst_cmd",   48'(cmd),   48'd1);
    chk("mrst_busy",  48'(busy),  48'd0);
    chk("mrst_done",  48'(done),  48'd0);
    cnt = 0;
    for (int t = 0; t < 60; t++) begin
      tick(1'b1);
      if (done || en) cnt++;
    end
    chk("mrst_quiet", 48'(cnt), 48'd0);

    idx = 6'd0;
    arg = 32'h0;
    valid = 1'b1;
    tick(1'b0);
    run_frame(1, bits, nb, nd, lat, uns);
    chk("b2b_first_bits", bits, F0);
    chk("b2b_ready_done", 48'(ready), 48'd0);
    w = 0;
    while (!ready && w < 50) begin
      tick(1'b1);
      w++;
    end
`ifdef SDHCI_CMD_TX_NCC_EN
    chk("b2b_gap", 48'(w), 48'd8);
`else
    chk("b2b_gap", 48'(w), 48'd1);
`endif
    tick(1'b1);
    valid = 1'b0;
    chk("b2b_accept", 48'(ready), 48'd0);
    run_frame(1, bits, nb, nd, lat, uns);
    chk("b2b_second_bits", bits, F0);
    chk("b2b_second_done", 48'(nd), 48'd1);
    tick(1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
